cfeb_jtag_seq: RTL and testbench
================================

CFEB_JTAG_SEQ -- requirements
Module: cfeb_jtag_seq

Interface
REQ-001 Parameter IR_LEN, default 8, instruction register length in bits (1..16).
REQ-002 Parameter TMO, default 1023, DTACK timeout in FASTCLK cycles (1..4095).
REQ-003 FASTCLK  in  1  sole clock; all state changes on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 START  in  1  one-cycle request to begin a scan.
REQ-006 CFEB_MASK  in  5  bit i-1 selects CFEB i; sampled on accepted START.
REQ-007 INSTR  in  16  instruction opcode, LSB shifted first; sampled on accepted START.
REQ-008 JTAG_DTACK_B  in  1  active-low transaction acknowledge from CFEB JTAG engine.
REQ-009 JTAG_RDATA  in  16  TDO readback word from engine.
REQ-010 JTAG_DEVICE  out  1  engine device select.
REQ-011 JTAG_STROBE  out  1  transaction strobe.
REQ-012 JTAG_COMMAND  out  10  engine command word.
REQ-013 JTAG_WDATA  out  16  engine write data.
REQ-014 BUSY  out  1  scan in progress.
REQ-015 DONE  out  1  one-cycle pulse at scan end.
REQ-016 ERR  out  1  sticky timeout flag, cleared on accepted START or RST.
REQ-017 VALID_MASK  out  5  bit i-1 set when CFEB i result complete.
REQ-018 RESULT_SEL  in  3  CFEB number 1..5 for RESULT; other values give RESULT=0.
REQ-019 RESULT  out  32  combinational read of selected result register.

Function
REQ-020 States: IDLE, SETUP, STRB, REL, NEXT, FIN; step counter 0..6; CFEB index 1..5.
REQ-021 IDLE: START accepted -> latch mask/INSTR, clear results, VALID_MASK, ERR; BUSY=1; go NEXT with index=0. START while BUSY ignored.
REQ-022 NEXT: advance index to lowest masked CFEB above current, step=0, go SETUP; none left -> FIN.
REQ-023 Steps: 0 cmd 0x008, WDATA={11'b0,onehot(index)}; 1 cmd 0x006; 2 cmd {IR_LEN-1 [9:6],6'd7}, WDATA=INSTR; 3 cmd 0x3C1, WDATA=0; 4 cmd 0x005; 5 cmd 0x3C2, WDATA=0; 6 cmd 0x005.
REQ-024 SETUP: JTAG_DEVICE=1, COMMAND/WDATA driven; wait until DTACK_B=1 sampled, then go STRB next cycle (min 1 cycle setup before STROBE).
REQ-025 STRB: JTAG_STROBE=1; on DTACK_B=0 sampled: step 4 captures RDATA into result[15:0], step 6 into result[31:16] and sets VALID_MASK bit; go REL.
REQ-026 REL: STROBE=0, COMMAND/WDATA/DEVICE held; wait DTACK_B=1, then step<6 -> step+1, SETUP; step=6 -> NEXT.
REQ-027 COMMAND/WDATA/DEVICE stable from SETUP entry through REL exit; change only on SETUP entry.
REQ-028 Timeout: 12-bit counter cleared on SETUP entry, counts in SETUP/STRB/REL; reaching TMO -> ERR=1, STROBE=0, CFEB result left partial, VALID bit clear, go NEXT.
REQ-029 FIN: DONE=1 one cycle, BUSY=0, DEVICE=0, go IDLE.
REQ-030 Mask 0: START -> FIN -> DONE 2 cycles after START, no STROBE.
REQ-031 CFEBs scanned in ascending order; exactly 7 strobes per non-timed-out CFEB.

Reset
REQ-032 RST (any state) -> IDLE next edge; STROBE, DEVICE, BUSY, DONE, ERR=0; COMMAND=0, WDATA=0; VALID_MASK=0; results=0.
REQ-033 RST dominates simultaneous START.

Verification
REQ-034 Mask=5'b00101, engine model acks in 3 cycles, RDATA=0x1234 then 0x5678 -> 14 strobes, CFEB1 and CFEB3 RESULT=0x56781234, VALID_MASK=00101, DONE once, ERR=0.
REQ-035 Mask=5'b00010, no DTACK on step 2 -> ERR=1 after 1023 cycles, VALID_MASK=0, DONE pulse, no further strobes.
REQ-036 Mask=0 -> DONE 2 cycles after START, STROBE never asserted, BUSY one cycle.
REQ-037 RST asserted during STRB of CFEB 2 step 4 -> next edge STROBE=0, BUSY=0, VALID_MASK=0, RESULT=0 for all RESULT_SEL.
REQ-038 DTACK_B held low 10 cycles before step 0 -> SETUP waits; STROBE rises 1 cycle after DTACK_B returns high; COMMAND=0x008 stable throughout.
REQ-039 IR_LEN=5, INSTR=0x001F -> step 2 COMMAND=0x107, WDATA=0x001F; second START during BUSY ignored.

Source files
------------

// File: rtl/cfeb_jtag_seq.sv
// CFEB JTAG scan sequencer: walks the selected CFEBs in ascending order,
// issuing a fixed 7-step command sequence per CFEB to the JTAG engine.
module cfeb_jtag_seq #(
    parameter int IR_LEN = 8,
    parameter int TMO    = 1023
) (
    input  logic        FASTCLK,
    input  logic        RST,
    input  logic        START,
    input  logic [4:0]  CFEB_MASK,
    input  logic [15:0] INSTR,
    input  logic        JTAG_DTACK_B,
    input  logic [15:0] JTAG_RDATA,
    input  logic [2:0]  RESULT_SEL,
    output logic        JTAG_DEVICE,
    output logic        JTAG_STROBE,
    output logic [9:0]  JTAG_COMMAND,
    output logic [15:0] JTAG_WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [4:0]  VALID_MASK,
    output logic [31:0] RESULT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STRB,
        S_REL,
        S_NEXT,
        S_FIN
    } state_t;

    localparam logic [3:0]  IRL  = 4'(IR_LEN - 1);
    localparam logic [11:0] TLIM = 12'(TMO);

    state_t      state_q;
    state_t      state_d;
    logic [4:0]  mask_q;
    logic [15:0] instr_q;
    logic [2:0]  idx_q;
    logic [2:0]  step_q;
    logic [11:0] cnt_q;
    logic        err_q;
    logic [4:0]  valid_q;
    logic [9:0]  cmd_q;
    logic [15:0] wdata_q;
    logic        dev_q;
    logic [31:0] res_q [1:5];

    logic [2:0]  nxt_idx;
    logic        timeout;
    logic        ack;

    function automatic logic [4:0] onehot(input logic [2:0] i);
        onehot = (i == 3'd0) ? 5'd0 : (5'd1 << (i - 3'd1));
    endfunction

    // Lowest selected CFEB strictly above cur; 0 when none remain.
    function automatic logic [2:0] next_cfeb(
        input logic [4:0] m,
        input logic [2:0] cur
    );
        next_cfeb = 3'd0;
        for (int i = 5; i >= 1; i--) begin
            if (m[i-1] && (3'(i) > cur)) next_cfeb = 3'(i);
        end
    endfunction

    function automatic logic [9:0] step_cmd(input logic [2:0] s);
        unique case (s)
            3'd0:    step_cmd = 10'h008;
            3'd1:    step_cmd = 10'h006;
            3'd2:    step_cmd = {IRL, 6'd7};
            3'd3:    step_cmd = 10'h3C1;
            3'd4:    step_cmd = 10'h005;
            3'd5:    step_cmd = 10'h3C2;
            3'd6:    step_cmd = 10'h005;
            default: step_cmd = 10'h000;
        endcase
    endfunction

    function automatic logic [15:0] step_wdata(
        input logic [2:0]  s,
        input logic [2:0]  i,
        input logic [15:0] ins
    );
        unique case (s)
            3'd0:    step_wdata = {11'b0, onehot(i)};
            3'd2:    step_wdata = ins;
            default: step_wdata = 16'h0000;
        endcase
    endfunction

    assign nxt_idx = next_cfeb(mask_q, idx_q);
    assign ack     = ~JTAG_DTACK_B;
    assign timeout = (cnt_q == TLIM) &&
                     (state_q inside {S_SETUP, S_STRB, S_REL});

    always_ff @(posedge FASTCLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) state_d = S_NEXT;
            end
            S_NEXT: begin
                state_d = (nxt_idx != 3'd0) ? S_SETUP : S_FIN;
            end
            S_SETUP: begin
                if (timeout)           state_d = S_NEXT;
                else if (JTAG_DTACK_B) state_d = S_STRB;
            end
            S_STRB: begin
                if (timeout)  state_d = S_NEXT;
                else if (ack) state_d = S_REL;
            end
            S_REL: begin
                if (timeout) begin
                    state_d = S_NEXT;
                end else if (JTAG_DTACK_B) begin
                    state_d = (step_q == 3'd6) ? S_NEXT : S_SETUP;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        JTAG_STROBE = (state_q == S_STRB);
        BUSY        = state_q inside {S_SETUP, S_STRB, S_REL, S_NEXT};
        DONE        = (state_q == S_FIN);
    end

    // Command, data and device only change on SETUP entry.
    always_ff @(posedge FASTCLK) begin
        if (RST) begin
            mask_q  <= '0;
            instr_q <= '0;
            idx_q   <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= '0;
            cmd_q   <= '0;
            wdata_q <= '0;
            dev_q   <= 1'b0;
            for (int i = 1; i <= 5; i++) res_q[i] <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (START) begin
                        mask_q  <= CFEB_MASK;
                        instr_q <= INSTR;
                        idx_q   <= 3'd0;
                        err_q   <= 1'b0;
                        valid_q <= '0;
                        for (int i = 1; i <= 5; i++) res_q[i] <= '0;
                    end
                end
                S_NEXT: begin
                    if (nxt_idx != 3'd0) begin
                        idx_q   <= nxt_idx;
                        step_q  <= 3'd0;
                        cnt_q   <= '0;
                        dev_q   <= 1'b1;
                        cmd_q   <= step_cmd(3'd0);
                        wdata_q <= step_wdata(3'd0, nxt_idx, instr_q);
                    end else begin
                        dev_q <= 1'b0;
                    end
                end
                S_SETUP, S_STRB, S_REL: begin
                    cnt_q <= cnt_q + 12'd1;
                    if (timeout) begin
                        err_q <= 1'b1;
                    end else if (state_q == S_STRB && ack) begin
                        if (step_q == 3'd4) begin
                            res_q[idx_q][15:0] <= JTAG_RDATA;
                        end
                        if (step_q == 3'd6) begin
                            res_q[idx_q][31:16] <= JTAG_RDATA;
                            valid_q <= valid_q | onehot(idx_q);
                        end
                    end else if (state_q == S_REL && JTAG_DTACK_B &&
                                 step_q != 3'd6) begin
                        step_q  <= step_q + 3'd1;
                        cnt_q   <= '0;
                        cmd_q   <= step_cmd(step_q + 3'd1);
                        wdata_q <= step_wdata(step_q + 3'd1, idx_q, instr_q);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        unique case (RESULT_SEL)
            3'd1:    RESULT = res_q[1];
            3'd2:    RESULT = res_q[2];
            3'd3:    RESULT = res_q[3];
            3'd4:    RESULT = res_q[4];
            3'd5:    RESULT = res_q[5];
            default: RESULT = 32'h0;
        endcase
    end

    assign JTAG_DEVICE  = dev_q;
    assign JTAG_COMMAND = cmd_q;
    assign JTAG_WDATA   = wdata_q;
    assign ERR          = err_q;
    assign VALID_MASK   = valid_q;

endmodule

// File: tb/tb_cfeb_jtag_seq.sv
// Directed bench for cfeb_jtag_seq with a small JTAG engine model
// acknowledging strobes after 3 cycles.
module tb_cfeb_jtag_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  mask = '0;
    logic [15:0] instr = '0;
    logic        dtack_b = 1'b1;
    logic [15:0] rdata = '0;
    logic [2:0]  sel = '0;
    logic        dev;
    logic        strobe;
    logic [9:0]  cmd;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  vmask;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    logic force_low = 1'b0;
    logic no_ack2 = 1'b0;
    int   ack_cnt = 0;
    int   strobes = 0;
    int   dones = 0;
    int   n005 = 0;
    logic strobe_prev = 1'b0;
    logic [15:0] sel_q [$];

    cfeb_jtag_seq #(.IR_LEN(5), .TMO(1023)) dut (
        .FASTCLK      (clk),
        .RST          (rst),
        .START        (start),
        .CFEB_MASK    (mask),
        .INSTR        (instr),
        .JTAG_DTACK_B (dtack_b),
        .JTAG_RDATA   (rdata),
        .RESULT_SEL   (sel),
        .JTAG_DEVICE  (dev),
        .JTAG_STROBE  (strobe),
        .JTAG_COMMAND (cmd),
        .JTAG_WDATA   (wdata),
        .BUSY         (busy),
        .DONE         (done),
        .ERR          (err),
        .VALID_MASK   (vmask),
        .RESULT       (result)
    );

    always #5 clk = ~clk;

    // Engine model and event monitor, acting 2 time units after each edge.
    always @(posedge clk) begin
        #2;
        if (cmd == 10'h3C1) rdata = 16'h1234;
        if (cmd == 10'h3C2) rdata = 16'h5678;
        if (force_low) begin
            dtack_b = 1'b0;
            ack_cnt = 0;
        end else if (strobe && !(no_ack2 && cmd[5:0] == 6'd7)) begin
            ack_cnt++;
            if (ack_cnt >= 3) dtack_b = 1'b0;
        end else if (!strobe) begin
            dtack_b = 1'b1;
            ack_cnt = 0;
        end
        if (strobe && !strobe_prev) begin
            strobes++;
            if (cmd == 10'h005) n005++;
            if (cmd == 10'h008) sel_q.push_back(wdata);
        end
        strobe_prev = strobe;
        if (done) dones++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input logic [4:0] m, input logic [15:0] ins);
        mask = m;
        instr = ins;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_counts();
        strobes = 0;
        dones = 0;
        n005 = 0;
        sel_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        mask = 5'b11111;
        tick();
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got=%b exp=0", busy);
        end
        checks++;
        if ({strobe, dev, done, err} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_flags got=%b exp=0000",
                     {strobe, dev, done, err});
        end
        checks++;
        if (cmd !== 10'h000 || wdata !== 16'h0000) begin
            errors++;
            $display("FAIL rst_cmd got=%h/%h exp=000/0000", cmd, wdata);
        end
        checks++;
        if (vmask !== 5'b00000) begin
            errors++;
            $display("FAIL rst_valid got=%b exp=00000", vmask);
        end
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            checks++;
            if (result !== 32'h0) begin
                errors++;
                $display("FAIL rst_result sel=%0d got=%h exp=0", s, result);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle got=%b exp=0", busy);
        end
    endtask

    task automatic test_mask0();
        clear_counts();
        do_start(5'b00000, 16'h0000);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL m0_c1 got=%b%b exp=10", busy, done);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL m0_c2 got=%b%b exp=01", busy, done);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL m0_c3 got=%b%b exp=00", busy, done);
        end
        tick();
        checks++;
        if (strobes !== 0) begin
            errors++;
            $display("FAIL m0_strobes got=%0d exp=0", strobes);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit found;
        clear_counts();
        no_ack2 = 1'b1;
        do_start(5'b00010, 16'h00A5);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (strobe && cmd[5:0] == 6'd7) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL to_step2 got=absent exp=present");
        end
        n = 0;
        while (strobe && n < 1100) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 1023) begin
            errors++;
            $display("FAIL to_len got=%0d exp=1023", n);
        end
        checks++;
        if (err !== 1'b1 || vmask !== 5'b00000) begin
            errors++;
            $display("FAIL to_err got=%b/%b exp=1/00000", err, vmask);
        end
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (done) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL to_done got=absent exp=present");
        end
        repeat (5) tick();
        checks++;
        if (strobes !== 3 || dones !== 1) begin
            errors++;
            $display("FAIL to_counts got=%0d/%0d exp=3/1", strobes, dones);
        end
        sel = 3'd2;
        #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL to_end got=%b/%b/%h exp=1/0/0", err, busy, result);
        end
        no_ack2 = 1'b0;
    endtask

    task automatic test_two_cfebs();
        bit found;
        clear_counts();
        do_start(5'b00101, 16'h001F);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tc_start got=%b/%b exp=0/1", err, busy);
        end
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (strobe && cmd[5:0] == 6'd7) found = 1;
            else tick();
        end
        checks++;
        if (cmd !== 10'h107 || wdata !== 16'h001F) begin
            errors++;
            $display("FAIL tc_step2 got=%h/%h exp=107/001f", cmd, wdata);
        end
        do_start(5'b11111, 16'hFFFF);
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (done) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL tc_done got=absent exp=present");
        end
        repeat (5) tick();
        checks++;
        if (strobes !== 14 || dones !== 1) begin
            errors++;
            $display("FAIL tc_counts got=%0d/%0d exp=14/1", strobes, dones);
        end
        checks++;
        if (sel_q.size() != 2 || sel_q[0] !== 16'h0001 ||
            sel_q[1] !== 16'h0004) begin
            errors++;
            $display("FAIL tc_order got=%0d entries exp=0001,0004",
                     sel_q.size());
        end
        checks++;
        if (vmask !== 5'b00101 || err !== 1'b0) begin
            errors++;
            $display("FAIL tc_valid got=%b/%b exp=00101/0", vmask, err);
        end
        sel = 3'd1;
        #1;
        checks++;
        if (result !== 32'h56781234) begin
            errors++;
            $display("FAIL tc_res1 got=%h exp=56781234", result);
        end
        sel = 3'd3;
        #1;
        checks++;
        if (result !== 32'h56781234) begin
            errors++;
            $display("FAIL tc_res3 got=%h exp=56781234", result);
        end
        sel = 3'd2;
        #1;
        checks++;
        if (result !== 32'h0) begin
            errors++;
            $display("FAIL tc_res2 got=%h exp=0", result);
        end
        sel = 3'd7;
        #1;
        checks++;
        if (result !== 32'h0) begin
            errors++;
            $display("FAIL tc_res7 got=%h exp=0", result);
        end
    endtask

    task automatic test_dtack_hold();
        bit found;
        clear_counts();
        force_low = 1'b1;
        tick();
        tick();
        do_start(5'b00001, 16'h0000);
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (strobe !== 1'b0 || cmd !== 10'h008 || dev !== 1'b1) begin
                errors++;
                $display("FAIL dh_wait i=%0d got=%b/%h exp=0/008",
                         i, strobe, cmd);
            end
            tick();
        end
        force_low = 1'b0;
        found = 0;
        for (int i = 0; i < 5 && !found; i++) begin
            if (dtack_b) found = 1;
            else tick();
        end
        checks++;
        if (strobe !== 1'b0) begin
            errors++;
            $display("FAIL dh_early got=%b exp=0", strobe);
        end
        tick();
        checks++;
        if (strobe !== 1'b1 || cmd !== 10'h008 || wdata !== 16'h0001) begin
            errors++;
            $display("FAIL dh_rise got=%b/%h/%h exp=1/008/0001",
                     strobe, cmd, wdata);
        end
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (done) found = 1;
            else tick();
        end
        repeat (3) tick();
        sel = 3'd1;
        #1;
        checks++;
        if (strobes !== 7 || vmask !== 5'b00001 ||
            result !== 32'h56781234) begin
            errors++;
            $display("FAIL dh_end got=%0d/%b/%h exp=7/00001/56781234",
                     strobes, vmask, result);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        clear_counts();
        do_start(5'b00011, 16'h0000);
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (n005 == 3 && strobe) found = 1;
            else tick();
        end
        sel = 3'd1;
        #1;
        checks++;
        if (!found || vmask !== 5'b00001 || result !== 32'h56781234) begin
            errors++;
            $display("FAIL rm_pre got=%b/%h exp=00001/56781234",
                     vmask, result);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (strobe !== 1'b0 || busy !== 1'b0 || vmask !== 5'b0) begin
            errors++;
            $display("FAIL rm_post got=%b/%b/%b exp=0/0/00000",
                     strobe, busy, vmask);
        end
        checks++;
        if (dev !== 1'b0 || cmd !== 10'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rm_out got=%b/%h/%b exp=0/000/0", dev, cmd, err);
        end
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            checks++;
            if (result !== 32'h0) begin
                errors++;
                $display("FAIL rm_result sel=%0d got=%h exp=0", s, result);
            end
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_mask0();
        test_timeout();
        test_two_cfebs();
        test_dtack_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
